// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Pipeline stall/flush controller with saturating perf counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             nrst_i,
    input  logic             ihit_i,
    input  logic             dhit_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             ifid_uses_rs_i,
    input  logic             ifid_uses_rt_i,
    input  logic             idex_dREN_i,
    input  logic [4:0]       idex_wsel_i,
    input  logic             ex_redirect_i,
    input  logic             exmem_dREN_i,
    input  logic             exmem_dWEN_i,
    input  logic             memwb_halt_i,
    output logic             pc_en_o,
    output logic             ifid_en_o,
    output logic             ifid_flush_o,
    output logic             idex_en_o,
    output logic             idex_flush_o,
    output logic             exmem_en_o,
    output logic             memwb_en_o,
    output logic             halt_o,
    output logic [CNT_W-1:0] cyc_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [0:0] {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic             halt_q, halt_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic dwait;
    logic loaduse;
    logic cyc_inc, stall_inc, flush_inc;

    assign dwait   = (exmem_dREN_i | exmem_dWEN_i) & ~dhit_i;
    // $0 is hardwired zero, so a load targeting it can never be a real dependency.
    assign loaduse = idex_dREN_i & (idex_wsel_i != 5'd0) &
                     ((ifid_uses_rs_i & (ifid_rs_i == idex_wsel_i)) |
                      (ifid_uses_rt_i & (ifid_rt_i == idex_wsel_i)));

    always_comb begin
        state_d      = state_q;
        halt_d       = halt_q;
        pc_en_o      = 1'b0;
        ifid_en_o    = 1'b0;
        ifid_flush_o = 1'b0;
        idex_en_o    = 1'b0;
        idex_flush_o = 1'b0;
        exmem_en_o   = 1'b0;
        memwb_en_o   = 1'b0;
        cyc_inc      = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;

        if (nrst_i && state_q == S_RUN) begin
            cyc_inc = 1'b1;
            if (memwb_halt_i) begin
                state_d = S_HALTED;
                halt_d  = 1'b1;
            end else if (dwait) begin
                // Full freeze; any redirect or load-use is re-evaluated once the access lands.
                stall_inc = 1'b1;
            end else if (ex_redirect_i) begin
                pc_en_o      = 1'b1;
                ifid_en_o    = 1'b1;
                ifid_flush_o = 1'b1;
                idex_en_o    = 1'b1;
                idex_flush_o = 1'b1;
                exmem_en_o   = 1'b1;
                memwb_en_o   = 1'b1;
                flush_inc    = 1'b1;
            end else if (loaduse) begin
                idex_en_o    = 1'b1;
                idex_flush_o = 1'b1;
                exmem_en_o   = 1'b1;
                memwb_en_o   = 1'b1;
                stall_inc    = 1'b1;
            end else if (!ihit_i) begin
                ifid_en_o    = 1'b1;
                ifid_flush_o = 1'b1;
                idex_en_o    = 1'b1;
                exmem_en_o   = 1'b1;
                memwb_en_o   = 1'b1;
                stall_inc    = 1'b1;
            end else begin
                pc_en_o    = 1'b1;
                ifid_en_o  = 1'b1;
                idex_en_o  = 1'b1;
                exmem_en_o = 1'b1;
                memwb_en_o = 1'b1;
            end
        end
    end

    always_comb begin
        cyc_d   = cyc_q;
        stall_d = stall_q;
        flush_d = flush_q;
        if (cyc_inc && cyc_q != CNT_MAX)
            cyc_d = cyc_q + CNT_W'(1);
        if (stall_inc && stall_q != CNT_MAX)
            stall_d = stall_q + CNT_W'(1);
        if (flush_inc && flush_q != CNT_MAX)
            flush_d = flush_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            state_q <= S_RUN;
            halt_q  <= 1'b0;
            cyc_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
            cyc_q   <= cyc_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign halt_o      = halt_q;
    assign cyc_cnt_o   = cyc_q;
    assign stall_cnt_o = stall_q;
    assign flush_cnt_o = flush_q;

endmodule

`default_nettype wire
